mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles without ack before the access is abandoned (legal range 2..255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports listed below.
REQ-003 SHALL have port clk  in  1  rising-edge clock shared with the pipeline registers.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port MemRead  in  1  load request from the EX/MEM register.
REQ-006 SHALL have port MemWrite  in  1  store request from the EX/MEM register.
REQ-007 SHALL have port Address  in  32  byte address from the EX/MEM register.
REQ-008 SHALL have port WD  in  32  store data from the EX/MEM register.
REQ-009 SHALL have port mem_req  out  1  data-memory request, level-held until ack.
REQ-010 SHALL have port mem_we  out  1  1 means write, 0 means read; valid while mem_req=1.
REQ-011 SHALL have port mem_addr  out  32  memory address.
REQ-012 SHALL have port mem_wdata  out  32  memory write data.
REQ-013 SHALL have port mem_ack  in  1  memory completion, single-cycle pulse.
REQ-014 SHALL have port mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-015 SHALL have port Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-016 SHALL have port ReadData  out  32  registered load data for MEM/WB.
REQ-017 SHALL have port Err  out  1  sticky timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-019 SHALL, in IDLE with MemRead|MemWrite=1, combinationally drive Stall=1 and mem_req=1 in that same cycle, then go to WAIT.
REQ-020 SHALL, in IDLE with no access, hold Stall=0 and mem_req=0 and stay in IDLE.
REQ-021 SHALL hold mem_req=1, Stall=1 and mem_addr/mem_wdata/mem_we constant throughout WAIT, including the cycle in which mem_ack=1.
REQ-022 SHALL pass mem_addr=Address and mem_wdata=WD straight through; these stay stable because EX/MEM is frozen by Stall.
REQ-023 SHALL, when MemWrite=1, drive mem_we=1, and SHALL give MemWrite priority when MemRead=MemWrite=1.
REQ-024 SHALL, on mem_ack=1 in WAIT, capture mem_rdata into ReadData for a read (ReadData unchanged for a write) and go to DONE.
REQ-025 SHALL drive Stall=0 and mem_req=0 in DONE, ignore MemRead/MemWrite there (same instruction still in EX/MEM), and return to IDLE next cycle.
REQ-026 SHALL give a total stall of 1 + (cycles until ack) cycles; an ack in the first WAIT cycle gives Stall high for exactly 2 cycles.
REQ-027 SHALL count WAIT cycles in an 8-bit counter cleared on entry to WAIT.
REQ-028 SHALL, when the count reaches TIMEOUT-1 with no ack, set Err=1, load ReadData=32'hDEADBEEF for a read, and go to DONE.
REQ-029 SHALL ignore mem_ack outside WAIT.
REQ-030 SHALL allow back-to-back accesses, giving IDLE->WAIT->...->DONE->IDLE->WAIT with one Stall-low cycle (DONE) between them.
REQ-031 SHALL clear Err only by reset.

Reset
REQ-032 SHALL, on rst=1, asynchronously force state=IDLE, counter=0, ReadData=0 and Err=0.
REQ-033 SHALL drive mem_req=0 and Stall=0 while rst=1, even mid-WAIT, so that an outstanding access is dropped.
REQ-034 SHALL evaluate the first access on the first rising edge after rst deasserts.

Structure
REQ-035 SHALL define the state enum, the DEADBEEF poison constant and the TIMEOUT default in a shared package mem_ctrl_pkg.
REQ-036 SHALL place the WAIT counter and timeout compare in one sub-module, wait_timer (inputs clr, en; output expired).

Verification
REQ-037 SHALL verify the basic load: MemRead=1, Address=0x40, ack after 3 WAIT cycles with mem_rdata=0x12345678 -> Stall high 4 cycles, then ReadData=0x12345678, Stall low in DONE.
REQ-038 SHALL verify the store: MemWrite=1, WD=0xCAFEF00D, Address=0x80 -> mem_we=1, mem_wdata=0xCAFEF00D held until ack, ReadData unchanged.
REQ-039 SHALL verify timeout: load with no ack, TIMEOUT=15 -> after 15 WAIT cycles ReadData=0xDEADBEEF, Err=1 sticky, FSM back in IDLE.
REQ-040 SHALL verify simultaneous requests: MemRead=MemWrite=1 -> mem_we=1 (write wins).
REQ-041 SHALL verify back-to-back loads: ack in the first WAIT cycle each time -> Stall pattern 1,1,0,1,1,0.
REQ-042 SHALL verify reset mid-operation: rst asserted in the 2nd WAIT cycle -> mem_req and Stall fall immediately, Err=0, next access starts cleanly from IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and constants for the data-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returned as load data when the memory never acknowledges.
    localparam logic [31:0] POISON          = 32'hDEADBEEF;
    localparam int          TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// wait_timer: counts WAIT cycles and flags the last cycle allowed before the access is abandoned.
module wait_timer
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
        expired = en && (cnt_q == 8'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: stalls the pipeline while a load/store waits for a level-held
// memory handshake, registering load data and flagging accesses that time out.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WD,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        Err
);

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        access, tmr_clr, tmr_en, expired;

    assign access = MemRead | MemWrite;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    // EX/MEM is frozen by Stall, so the request fields can pass straight through;
    // any access that is not a write is treated as a read.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmr_clr = 1'b0;
        tmr_en  = (state_q == WAIT);
        case (state_q)
            IDLE: if (access) begin
                state_d = WAIT;
                tmr_clr = 1'b1;
            end
            WAIT: if (mem_ack) begin
                state_d = DONE;
                rdata_d = MemWrite ? rdata_q : mem_rdata;
            end else if (expired) begin
                state_d = DONE;
                err_d   = 1'b1;
                rdata_d = MemWrite ? rdata_q : POISON;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst so an outstanding request drops the moment reset asserts.
    assign Stall     = !rst && ((state_q == IDLE && access) || state_q == WAIT);
    assign mem_req   = Stall;
    assign mem_we    = MemWrite;
    assign mem_addr  = Address;
    assign mem_wdata = WD;
    assign ReadData  = rdata_q;
    assign Err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scenario tasks drive accesses and push expected completions;
// a negedge monitor pops them when a stall window closes.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst, MemRead, MemWrite, mem_ack;
    logic [31:0] Address, WD, mem_rdata;
    logic        mem_req, mem_we, Stall, Err;
    logic [31:0] mem_addr, mem_wdata, ReadData;

    typedef struct {
        int          stall;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          stall_cnt = 0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err   = 1'b0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WD        (WD),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .Stall     (Stall),
        .ReadData  (ReadData),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) stall_cnt = 0;
        else if (Stall) stall_cnt++;
        else if (stall_cnt > 0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: completion after %0d stall cycles with nothing expected", stall_cnt);
            end else begin
                mon_e = sb.pop_front();
                n_tests++;
                if (stall_cnt !== mon_e.stall) begin
                    n_fail++;
                    $display("FAIL stall_len: got %0d cycles, expected %0d", stall_cnt, mon_e.stall);
                end
                n_tests++;
                if (ReadData !== mon_e.rdata) begin
                    n_fail++;
                    $display("FAIL done_rdata: got %h, expected %h", ReadData, mon_e.rdata);
                end
                n_tests++;
                if (Err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL done_err: got %b, expected %b", Err, mon_e.err);
                end
            end
            stall_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            step();
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            mem_ack  = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({mem_req, Stall} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle: req=%b stall=%b, expected 0 0", mem_req, Stall);
            end
        end
    endtask

    // n = WAIT cycle (1-based) carrying the ack; n = 0 means never ack.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int n, input logic [31:0] rdata);
        exp_t e;
        int   len;
        len = (n > 0) ? n + 1 : TO + 1;
        if (!wr) m_rdata = (n > 0) ? rdata : POISON;
        if (n == 0) m_err = 1'b1;
        e.stall = len;
        e.rdata = m_rdata;
        e.err   = m_err;
        sb.push_back(e);
        step();
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WD        = wd;
        mem_rdata = rdata;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            n_tests++;
            if ({mem_req, Stall, mem_we, mem_addr, mem_wdata} !== {2'b11, wr, addr, wd}) begin
                n_fail++;
                $display("FAIL access_hold cyc %0d: req=%b stall=%b we=%b addr=%h wdata=%h, expected 1 1 %b %h %h",
                         i, mem_req, Stall, mem_we, mem_addr, mem_wdata, wr, addr, wd);
            end
            step();
            mem_ack = (n > 0 && i + 1 == n);
        end
        @(negedge clk);
        n_tests++;
        if ({mem_req, Stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_state: req=%b stall=%b, expected 0 0", mem_req, Stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; mem_ack = 1'b0;
        Address = 32'h0; WD = 32'h0; mem_rdata = 32'h0;
        #3;
        n_tests++;
        if ({mem_req, Stall, Err, ReadData} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset: req=%b stall=%b err=%b rdata=%h, expected 0 0 0 0", mem_req, Stall, Err, ReadData);
        end
        step();
        rst = 1'b0;
        MemRead = 1'b0;
        idle(2);
    endtask

    task automatic test_ack_ignored();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({Stall, ReadData} !== {1'b0, m_rdata}) begin
            n_fail++;
            $display("FAIL ack_ignored: stall=%b rdata=%h, expected 0 %h", Stall, ReadData, m_rdata);
        end
    endtask

    task automatic test_load();
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h12345678);
        idle(2);
        n_tests++;
        if (ReadData !== 32'h12345678) begin
            n_fail++;
            $display("FAIL load_rdata: got %h, expected 12345678", ReadData);
        end
    endtask

    task automatic test_store();
        do_access(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 2, 32'hFFFFFFFF);
        idle(1);
    endtask

    task automatic test_simultaneous();
        do_access(1'b1, 1'b1, 32'hC0, 32'h0BADF00D, 1, 32'h11111111);
        idle(1);
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hA1A1A1A1);
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 1, 32'hB2B2B2B2);
        idle(1);
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h77777777);
        idle(3);
        n_tests++;
        if ({Err, ReadData} !== {1'b1, POISON}) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b rdata=%h, expected 1 %h", Err, ReadData, POISON);
        end
        do_access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h3C3C3C3C);
        idle(1);
    endtask

    task automatic test_reset_mid();
        step();
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Address  = 32'h300;
        step();
        step();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, Stall, Err, ReadData} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b stall=%b err=%b rdata=%h, expected 0 0 0 0", mem_req, Stall, Err, ReadData);
        end
        m_rdata = 32'h0;
        m_err   = 1'b0;
        step();
        rst     = 1'b0;
        MemRead = 1'b0;
        idle(1);
        do_access(1'b1, 1'b0, 32'h304, 32'h0, 2, 32'h9E9E9E9E);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_ack_ignored();
        test_load();
        test_store();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected completions never seen, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
